// File: rtl/control_loop_dac_out_if.sv
// SPI-side handshake bundle for control_loop_dac_out.
// master drives the framed word and request; slave returns completion.
interface control_loop_dac_out_if #(
  parameter int WORD_W = 24
);
  logic [WORD_W-1:0] spi_word;
  logic              spi_arm;
  logic              spi_finished;

  modport master (
    output spi_word,
    output spi_arm,
    input  spi_finished
  );

  modport slave (
    input  spi_word,
    input  spi_arm,
    output spi_finished
  );
endinterface

// File: rtl/control_loop_dac_out.sv
// Scales a Q21.43 adjustment to DAC counts (bit-serial), saturates, writes via SPI.
// Optional output slew limiting: define CONTROL_LOOP_DAC_SLEW_EN.
module control_loop_dac_out #(
  parameter int CONSTS_WHOLE = 21,
  parameter int CONSTS_FRAC  = 43,
  parameter int DAC_WID      = 20,
  parameter int SCALE_WID    = 19,
  parameter int SCALE_FRAC   = 16,
  parameter logic [SCALE_WID-1:0] DAC_SCALE = 268435,
  parameter logic [3:0] DAC_CMD = 4'b0001
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_arm,
  output logic                 o_finished,
  input  logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] i_adj_val,
  output logic [DAC_WID-1:0]   o_dac_code,
  output logic                 o_saturated,
`ifdef CONTROL_LOOP_DAC_SLEW_EN
  input  logic [DAC_WID-2:0]   i_slew_max,
`endif
  control_loop_dac_out_if.master spi
);

  localparam int ADJ_W = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int ACC_W = ADJ_W + SCALE_WID;
  localparam int SHIFT = CONSTS_FRAC + SCALE_FRAC;
  localparam int CNT_W = $clog2(SCALE_WID);
  localparam int WRD_W = DAC_WID + 4;

  localparam logic signed [ACC_W-1:0] CODE_MAX =
    ACC_W'((2 ** (DAC_WID - 1)) - 1);
  localparam logic signed [ACC_W-1:0] CODE_MIN =
    ACC_W'(-(2 ** (DAC_WID - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SAT,
`ifdef CONTROL_LOOP_DAC_SLEW_EN
    S_SLEW,
`endif
    S_SPI_REQ,
    S_SPI_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADJ_W-1:0]        r_adj;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [DAC_WID-1:0]      r_code;
  logic                    r_sat;
  logic [DAC_WID-1:0]      r_dac;
  logic                    r_finished;
  logic                    r_spi_arm;
  logic [WRD_W-1:0]        r_spi_word;

  logic signed [ACC_W-1:0] w_adj_ext;
  logic signed [ACC_W-1:0] w_addend;
  logic signed [ACC_W-1:0] w_shr;
  logic [DAC_WID-1:0]      w_sat_code;
  logic                    w_sat_hit;

  assign w_adj_ext = {{SCALE_WID{r_adj[ADJ_W-1]}}, r_adj};
  assign w_addend  = w_adj_ext << r_cnt;
  // Arithmetic shift floors toward -inf, matching the DAC rounding rule.
  assign w_shr     = r_acc >>> SHIFT;

  always_comb begin
    w_sat_code = w_shr[DAC_WID-1:0];
    w_sat_hit  = 1'b0;
    if (w_shr > CODE_MAX) begin
      w_sat_code = CODE_MAX[DAC_WID-1:0];
      w_sat_hit  = 1'b1;
    end else if (w_shr < CODE_MIN) begin
      w_sat_code = CODE_MIN[DAC_WID-1:0];
      w_sat_hit  = 1'b1;
    end
  end

`ifdef CONTROL_LOOP_DAC_SLEW_EN
  localparam logic signed [DAC_WID:0] LIM_MAX =
    (DAC_WID+1)'((2 ** (DAC_WID - 1)) - 1);
  localparam logic signed [DAC_WID:0] LIM_MIN =
    (DAC_WID+1)'(-(2 ** (DAC_WID - 1)));

  logic signed [DAC_WID:0] w_cur;
  logic signed [DAC_WID:0] w_req;
  logic signed [DAC_WID:0] w_lo;
  logic signed [DAC_WID:0] w_hi;
  logic signed [DAC_WID:0] w_slew_v;
  logic [DAC_WID-1:0]      w_slew_code;
  logic                    w_slew_hit;

  assign w_cur = {r_dac[DAC_WID-1], r_dac};
  assign w_req = {r_code[DAC_WID-1], r_code};
  assign w_lo  = w_cur - {2'b00, i_slew_max};
  assign w_hi  = w_cur + {2'b00, i_slew_max};

  always_comb begin
    w_slew_v   = w_req;
    w_slew_hit = 1'b0;
    if (w_req < w_lo) begin
      w_slew_v   = w_lo;
      w_slew_hit = 1'b1;
    end else if (w_req > w_hi) begin
      w_slew_v   = w_hi;
      w_slew_hit = 1'b1;
    end
    if (w_slew_v > LIM_MAX) begin
      w_slew_v = LIM_MAX;
    end else if (w_slew_v < LIM_MIN) begin
      w_slew_v = LIM_MIN;
    end
    w_slew_code = w_slew_v[DAC_WID-1:0];
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (i_arm) w_next = S_MUL;
      S_MUL:      if (r_cnt == CNT_W'(SCALE_WID - 1)) w_next = S_SAT;
`ifdef CONTROL_LOOP_DAC_SLEW_EN
      S_SAT:      w_next = S_SLEW;
      S_SLEW:     w_next = S_SPI_REQ;
`else
      S_SAT:      w_next = S_SPI_REQ;
`endif
      S_SPI_REQ:  if (!spi.spi_finished) w_next = S_SPI_WAIT;
      S_SPI_WAIT: if (spi.spi_finished) w_next = S_DONE;
      S_DONE:     if (!i_arm) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_adj      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_code     <= '0;
      r_sat      <= 1'b0;
      r_dac      <= '0;
      r_finished <= 1'b0;
      r_spi_arm  <= 1'b0;
      r_spi_word <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_finished <= 1'b0;
          if (i_arm) begin
            r_adj <= i_adj_val;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          if (DAC_SCALE[r_cnt]) r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_SAT: begin
          r_code <= w_sat_code;
          r_sat  <= w_sat_hit;
        end
`ifdef CONTROL_LOOP_DAC_SLEW_EN
        S_SLEW: begin
          r_code <= w_slew_code;
          r_sat  <= r_sat | w_slew_hit;
        end
`endif
        S_SPI_REQ: begin
          if (!spi.spi_finished) begin
            r_spi_word <= {DAC_CMD, r_code};
            r_spi_arm  <= 1'b1;
          end
        end
        S_SPI_WAIT: begin
          if (spi.spi_finished) begin
            r_spi_arm  <= 1'b0;
            r_dac      <= r_code;
            r_finished <= 1'b1;
          end
        end
        S_DONE: begin
          if (!i_arm) r_finished <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_finished   = r_finished;
  assign o_dac_code   = r_dac;
  assign o_saturated  = r_sat;
  assign spi.spi_word = r_spi_word;
  assign spi.spi_arm  = r_spi_arm;

endmodule

// File: tb/tb_control_loop_dac_out.sv
// Bench for control_loop_dac_out: scoreboard of expected SPI writes.
// Build with CONTROL_LOOP_DAC_SLEW_EN to also cover slew limiting.
module tb_control_loop_dac_out;

`ifdef CONTROL_LOOP_DAC_SLEW_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 21;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [63:0] adj = '0;
  logic        finished;
  logic [19:0] dac_code;
  logic        saturated;
`ifdef CONTROL_LOOP_DAC_SLEW_EN
  logic [18:0] slew_max = 19'h7FFFF;
`endif

  control_loop_dac_out_if u_spi ();

  control_loop_dac_out dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_arm       (arm),
    .o_finished  (finished),
    .i_adj_val   (adj),
    .o_dac_code  (dac_code),
    .o_saturated (saturated),
`ifdef CONTROL_LOOP_DAC_SLEW_EN
    .i_slew_max  (slew_max),
`endif
    .spi         (u_spi)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [20:0] sb[$];
  logic [19:0] model_dac = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct wide multiply, floor shift, clamp (and slew).
  function automatic logic [20:0] model(input logic [63:0] a);
    logic signed [127:0] p;
    logic signed [127:0] q;
    logic s;
    p = {{64{a[63]}}, a};
    p = p * 128'sd268435;
    q = p >>> 59;
    s = 1'b0;
    if (q > 128'sd524287) begin
      q = 128'sd524287;
      s = 1'b1;
    end else if (q < -128'sd524288) begin
      q = -128'sd524288;
      s = 1'b1;
    end
`ifdef CONTROL_LOOP_DAC_SLEW_EN
    begin
      longint cur, lo, hi, v;
      cur = {{44{model_dac[19]}}, model_dac};
      lo = cur - longint'(slew_max);
      hi = cur + longint'(slew_max);
      v = q[63:0];
      if (v < lo) begin v = lo; s = 1'b1; end
      else if (v > hi) begin v = hi; s = 1'b1; end
      if (v > 524287) v = 524287;
      if (v < -524288) v = -524288;
      q = {{64{v[63]}}, v};
    end
`endif
    return {s, q[19:0]};
  endfunction

  task automatic do_conv(input logic [63:0] a, input logic [20:0] e_in,
                         input string tag);
    logic [20:0] e;
    int n;
    sb.push_back(e_in);
    adj = a;
    arm = 1'b1;
    tick();
    adj = {$urandom, $urandom};
    n = 0;
    while (!u_spi.spi_arm && n < 200) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    n_total++;
    if (n !== LAT) begin
      $display("FAIL %s latency: got %0d want %0d", tag, n, LAT);
      if (!u_spi.spi_arm) begin
        arm = 1'b0;
        tick();
        return;
      end
    end else n_pass++;
    n_total++;
    if (u_spi.spi_word !== {4'b0001, e[19:0]})
      $display("FAIL %s word: got %h want %h", tag, u_spi.spi_word,
               {4'b0001, e[19:0]});
    else n_pass++;
    n_total++;
    if (dac_code !== model_dac)
      $display("FAIL %s dac_early: got %h want %h", tag, dac_code, model_dac);
    else n_pass++;
    repeat (3) tick();
    u_spi.spi_finished = 1'b1;
    n_total++;
    if (finished !== 1'b0)
      $display("FAIL %s fin_early: got %b want 0", tag, finished);
    else n_pass++;
    tick();
    n_total++;
    if (finished !== 1'b1 || u_spi.spi_arm !== 1'b0)
      $display("FAIL %s fin/arm: got %b/%b want 1/0", tag, finished,
               u_spi.spi_arm);
    else n_pass++;
    n_total++;
    if (dac_code !== e[19:0] || saturated !== e[20])
      $display("FAIL %s code/sat: got %h/%b want %h/%b", tag, dac_code,
               saturated, e[19:0], e[20]);
    else n_pass++;
    model_dac = e[19:0];
    u_spi.spi_finished = 1'b0;
    arm = 1'b0;
    tick();
    n_total++;
    if (finished !== 1'b0)
      $display("FAIL %s fin_drop: got %b want 0", tag, finished);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++;
    if ({finished, u_spi.spi_arm, saturated} !== 3'b000 ||
        dac_code !== 20'd0 || u_spi.spi_word !== 24'd0)
      $display("FAIL reset: got f%b a%b s%b d%h w%h want zeros", finished,
               u_spi.spi_arm, saturated, dac_code, u_spi.spi_word);
    else n_pass++;
    model_dac = '0;
  endtask

  task automatic test_convert();
    do_conv(64'd1 << 43,       {1'b0, 20'd4},      "one");
    do_conv(64'd1000 << 43,    {1'b0, 20'd4095},   "k1000");
    do_conv(-(64'd1 << 43),    {1'b0, 20'hFFFFB},  "neg_one");
    do_conv(-(64'd200000 << 43), {1'b1, 20'h80000}, "neg_sat");
    do_conv(64'd1 << 43,       {1'b0, 20'd4},      "one_b");
    do_conv(64'd200000 << 43,  {1'b1, 20'h7FFFF},  "pos_sat");
  endtask

  task automatic test_spi_busy();
    logic [20:0] e;
    u_spi.spi_finished = 1'b1;
    sb.push_back({1'b0, 20'd4095});
    adj = 64'd1000 << 43;
    arm = 1'b1;
    tick();
    repeat (LAT + 5) tick();
    n_total++;
    if (u_spi.spi_arm !== 1'b0)
      $display("FAIL busy_hold: got %b want 0", u_spi.spi_arm);
    else n_pass++;
    u_spi.spi_finished = 1'b0;
    tick();
    n_total++;
    if (u_spi.spi_arm !== 1'b1)
      $display("FAIL busy_release: got %b want 1", u_spi.spi_arm);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (u_spi.spi_word !== {4'b0001, e[19:0]})
      $display("FAIL busy_word: got %h want %h", u_spi.spi_word,
               {4'b0001, e[19:0]});
    else n_pass++;
    repeat (49) tick();
    n_total++;
    if (dac_code !== model_dac || finished !== 1'b0)
      $display("FAIL busy_wait: got %h/%b want %h/0", dac_code, finished,
               model_dac);
    else n_pass++;
    u_spi.spi_finished = 1'b1;
    tick();
    n_total++;
    if (finished !== 1'b1 || dac_code !== e[19:0])
      $display("FAIL busy_done: got %b/%h want 1/%h", finished, dac_code,
               e[19:0]);
    else n_pass++;
    model_dac = e[19:0];
    u_spi.spi_finished = 1'b0;
    arm = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    int n;
    adj = 64'd1000 << 43;
    arm = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    n_total++;
    if ({finished, u_spi.spi_arm, saturated} !== 3'b000 ||
        dac_code !== 20'd0 || u_spi.spi_word !== 24'd0)
      $display("FAIL rst_mul: got f%b a%b s%b d%h w%h want zeros", finished,
               u_spi.spi_arm, saturated, dac_code, u_spi.spi_word);
    else n_pass++;
    model_dac = '0;
    repeat (30) tick();
    n_total++;
    if (u_spi.spi_arm !== 1'b0)
      $display("FAIL rst_idle: got %b want 0", u_spi.spi_arm);
    else n_pass++;
    adj = 64'd1 << 43;
    arm = 1'b1;
    tick();
    n = 0;
    while (!u_spi.spi_arm && n < 200) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    n_total++;
    if (u_spi.spi_arm !== 1'b0 || dac_code !== 20'd0 || finished !== 1'b0)
      $display("FAIL rst_wait: got a%b d%h f%b want 0", u_spi.spi_arm,
               dac_code, finished);
    else n_pass++;
    do_conv(-(64'd1 << 43), {1'b0, 20'hFFFFB}, "after_rst");
  endtask

  task automatic test_arm_drop();
    logic [20:0] e;
    int n;
    sb.push_back({1'b0, 20'd4});
    adj = 64'd1 << 43;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n = 0;
    while (!u_spi.spi_arm && n < 200) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    n_total++;
    if (u_spi.spi_word !== {4'b0001, e[19:0]})
      $display("FAIL drop_word: got %h want %h", u_spi.spi_word,
               {4'b0001, e[19:0]});
    else n_pass++;
    u_spi.spi_finished = 1'b1;
    tick();
    u_spi.spi_finished = 1'b0;
    n_total++;
    if (finished !== 1'b1)
      $display("FAIL drop_pulse: got %b want 1", finished);
    else n_pass++;
    tick();
    n_total++;
    if (finished !== 1'b0 || dac_code !== e[19:0])
      $display("FAIL drop_end: got %b/%h want 0/%h", finished, dac_code,
               e[19:0]);
    else n_pass++;
    model_dac = e[19:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      a = $signed(a) >>> $urandom_range(3, 30);
      do_conv(a, model(a), $sformatf("rand%0d", i));
    end
  endtask

`ifdef CONTROL_LOOP_DAC_SLEW_EN
  task automatic test_slew();
    test_reset();
    slew_max = 19'd100;
    do_conv(64'd1000 << 43, {1'b1, 20'd100}, "slew100");
    slew_max = 19'd5000;
    do_conv(64'd1000 << 43, {1'b0, 20'd4095}, "slew5000");
    slew_max = 19'd1000;
    do_conv(-(64'd1 << 43), {1'b1, 20'd3095}, "slew_down");
    slew_max = 19'h7FFFF;
  endtask
`endif

  initial begin
    u_spi.spi_finished = 1'b0;
    test_reset();
    test_convert();
    test_spi_busy();
    test_rst_mid();
    test_arm_drop();
    test_back_to_back();
`ifdef CONTROL_LOOP_DAC_SLEW_EN
    test_slew();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
